// File: rtl/reaction_game_ctrl.sv
// Reaction-game sequencer: LED countdown, pseudo-random hold-off and a timed GO
// window, measuring the button response in ms from the upstream 1 ms tick.
module reaction_game_ctrl #(
  parameter int unsigned COUNTDOWN_STEPS = 4,
  parameter int unsigned STEP_MS         = 500,
  parameter int unsigned MIN_HOLD_MS     = 250,
  parameter int unsigned TIMEOUT_MS      = 999
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       msec_tick,
  input  logic       start,
  input  logic       button,
  output logic       presc_clr,
  output logic [2:0] state,
  output logic [7:0] cd_leds,
  output logic       go_led,
  output logic [9:0] react_ms,
  output logic       result_valid
);

  localparam int unsigned MS_W    = (STEP_MS > 1) ? $clog2(STEP_MS) : 1;
  localparam int unsigned STEP_W  = 3;
  localparam int unsigned HOLD_W  = 11;
  localparam int unsigned REACT_W = 10;
  localparam int unsigned LED_W   = 8;
  localparam int unsigned LFSR_W  = 16;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_HOLDOFF   = 3'd2,
    ST_GO        = 3'd3,
    ST_RESULT    = 3'd4,
    ST_DISQUAL   = 3'd5,
    ST_TIMEOUT   = 3'd6
  } state_e;

  state_e               state_q, state_d;
  logic [MS_W-1:0]      ms_cnt_q, ms_cnt_d;
  logic [STEP_W-1:0]    step_cnt_q, step_cnt_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [REACT_W-1:0]   react_cnt_q, react_cnt_d;
  logic [REACT_W-1:0]   react_ms_q, react_ms_d;
  logic [LED_W-1:0]     cd_leds_q, cd_leds_d;
  logic                 go_led_q, go_led_d;
  logic                 result_valid_q, result_valid_d;
  logic                 presc_clr_q, presc_clr_d;
  logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
  logic                 button_q, button_d;
  logic                 press_c;

  // Rising edge of the synchronized button; a held button never re-triggers.
  assign press_c  = button & ~button_q;
  assign button_d = button;

  // Fibonacci LFSR, taps 16,14,13,11; free-running so the hold-off depends on start time.
  assign lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      ms_cnt_q       <= '0;
      step_cnt_q     <= '0;
      hold_q         <= '0;
      react_cnt_q    <= '0;
      react_ms_q     <= '0;
      cd_leds_q      <= '0;
      go_led_q       <= 1'b0;
      result_valid_q <= 1'b0;
      presc_clr_q    <= 1'b0;
      lfsr_q         <= LFSR_SEED;
      button_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      ms_cnt_q       <= ms_cnt_d;
      step_cnt_q     <= step_cnt_d;
      hold_q         <= hold_d;
      react_cnt_q    <= react_cnt_d;
      react_ms_q     <= react_ms_d;
      cd_leds_q      <= cd_leds_d;
      go_led_q       <= go_led_d;
      result_valid_q <= result_valid_d;
      presc_clr_q    <= presc_clr_d;
      lfsr_q         <= lfsr_d;
      button_q       <= button_d;
    end
  end

  // Round sequencing; a press always outranks a same-cycle tick event.
  always_comb begin
    state_d        = state_q;
    ms_cnt_d       = ms_cnt_q;
    step_cnt_d     = step_cnt_q;
    hold_d         = hold_q;
    react_cnt_d    = react_cnt_q;
    react_ms_d     = react_ms_q;
    cd_leds_d      = cd_leds_q;
    result_valid_d = 1'b0;
    presc_clr_d    = 1'b0;

    case (state_q)
      ST_IDLE, ST_RESULT, ST_DISQUAL, ST_TIMEOUT: begin
        if (start) begin
          state_d     = ST_COUNTDOWN;
          presc_clr_d = 1'b1;
          ms_cnt_d    = '0;
          step_cnt_d  = '0;
          cd_leds_d   = LED_W'(1);
        end
      end
      ST_COUNTDOWN: begin
        if (press_c) begin
          state_d   = ST_DISQUAL;
          cd_leds_d = '0;
        end else if (msec_tick) begin
          if (ms_cnt_q == MS_W'(STEP_MS - 1)) begin
            ms_cnt_d = '0;
            if (step_cnt_q == STEP_W'(COUNTDOWN_STEPS - 1)) begin
              state_d   = ST_HOLDOFF;
              cd_leds_d = '0;
              hold_d    = HOLD_W'(MIN_HOLD_MS) + HOLD_W'(lfsr_q[9:0]);
            end else begin
              step_cnt_d = step_cnt_q + STEP_W'(1);
              cd_leds_d  = cd_leds_q << 1;
            end
          end else begin
            ms_cnt_d = ms_cnt_q + MS_W'(1);
          end
        end
      end
      ST_HOLDOFF: begin
        if (press_c) begin
          state_d   = ST_DISQUAL;
          cd_leds_d = '0;
        end else if (msec_tick) begin
          if (hold_q == HOLD_W'(1)) begin
            state_d     = ST_GO;
            react_cnt_d = '0;
            presc_clr_d = 1'b1;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
      end
      ST_GO: begin
        if (press_c) begin
          state_d        = ST_RESULT;
          react_ms_d     = react_cnt_q;
          result_valid_d = 1'b1;
        end else if (msec_tick) begin
          if (react_cnt_q == REACT_W'(TIMEOUT_MS - 1)) begin
            state_d        = ST_TIMEOUT;
            react_ms_d     = REACT_W'(TIMEOUT_MS);
            result_valid_d = 1'b1;
          end else begin
            react_cnt_d = react_cnt_q + REACT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    go_led_d = (state_d == ST_GO);
  end

  assign state        = state_q;
  assign cd_leds      = cd_leds_q;
  assign go_led       = go_led_q;
  assign react_ms     = react_ms_q;
  assign result_valid = result_valid_q;
  assign presc_clr    = presc_clr_q;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Bench for reaction_game_ctrl: a tick-level round model predicts every output
// each cycle, and directed rounds pin key results to hand-computed values.
module tb_reaction_game_ctrl;

  localparam int STEPS    = 3;
  localparam int STEP_MS  = 2;
  localparam int MIN_HOLD = 1;
  localparam int TIMEOUT  = 20;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       msec_tick = 1'b0;
  logic       start     = 1'b0;
  logic       button    = 1'b0;
  logic       presc_clr;
  logic [2:0] state;
  logic [7:0] cd_leds;
  logic       go_led;
  logic [9:0] react_ms;
  logic       result_valid;

  reaction_game_ctrl #(
    .COUNTDOWN_STEPS(STEPS),
    .STEP_MS        (STEP_MS),
    .MIN_HOLD_MS    (MIN_HOLD),
    .TIMEOUT_MS     (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .msec_tick   (msec_tick),
    .start       (start),
    .button      (button),
    .presc_clr   (presc_clr),
    .state       (state),
    .cd_leds     (cd_leds),
    .go_led      (go_led),
    .react_ms    (react_ms),
    .result_valid(result_valid)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Round model: phase uses the state-port numbering; timing kept as tick counts.
  int          m_phase, m_leds, m_react_ms, m_rv, m_pc;
  int          cd_ticks, hold_left, hold_load, react_ticks;
  logic [15:0] m_lfsr;
  logic        m_btn;
  int          cyc_n      = 0;
  int          tick_count = 0;
  bit          model_ok   = 0;

  always @(posedge clk) begin : model
    bit press;
    press = button && !m_btn;
    cyc_n++;
    if (msec_tick) tick_count++;
    if (reset) begin
      m_phase = 0; m_leds = 0; m_react_ms = 0; m_rv = 0; m_pc = 0;
      m_lfsr = 16'hACE1; m_btn = 1'b0; model_ok = 1;
    end else begin
      m_rv = 0; m_pc = 0; m_btn = button;
      case (m_phase)
        0, 4, 5, 6: if (start) begin
          m_phase = 1; m_pc = 1; cd_ticks = 0; m_leds = 1;
        end
        1: if (press) begin
          m_phase = 5; m_leds = 0;
        end else if (msec_tick) begin
          cd_ticks++;
          if (cd_ticks == STEPS * STEP_MS) begin
            m_leds = 0; m_phase = 2;
            hold_load = MIN_HOLD + int'(m_lfsr[9:0]);
            hold_left = hold_load;
          end else begin
            m_leds = 1 << (cd_ticks / STEP_MS);
          end
        end
        2: if (press) begin
          m_phase = 5;
        end else if (msec_tick) begin
          hold_left--;
          if (hold_left == 0) begin
            m_phase = 3; react_ticks = 0; m_pc = 1;
          end
        end
        3: if (press) begin
          m_react_ms = react_ticks; m_rv = 1; m_phase = 4;
        end else if (msec_tick) begin
          react_ticks++;
          if (react_ticks == TIMEOUT) begin
            m_react_ms = TIMEOUT; m_rv = 1; m_phase = 6;
          end
        end
        default: ;
      endcase
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  // Tick every 4 clocks, derived from the model's cycle count so stimulus can predict it.
  always @(negedge clk) msec_tick = (cyc_n % 4 == 3);

  always @(negedge clk) begin
    if (model_ok) begin
      chk("state",        int'(state),        m_phase);
      chk("cd_leds",      int'(cd_leds),      m_leds);
      chk("go_led",       int'(go_led),       int'(m_phase == 3));
      chk("react_ms",     int'(react_ms),     m_react_ms);
      chk("result_valid", int'(result_valid), m_rv);
      chk("presc_clr",    int'(presc_clr),    m_pc);
    end
  end

  function automatic bit tick_next();
    return (cyc_n % 4 == 3);
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic press_once();
    button = 1'b1; step(); button = 1'b0;
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int n = 0;
    while (int'(state) != s && n < budget) begin step(); n++; end
    chk(name, int'(state), s);
  endtask

  task automatic wait_leds(input int v, input int budget);
    int n = 0;
    while (int'(cd_leds) != v && n < budget) begin step(); n++; end
    chk("wait_cd_leds", int'(cd_leds), v);
  endtask

  initial begin : watchdog
    #1900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int d2, d4, g, t0, mode;
    step(3);
    reset = 1'b0;
    step();
    chk("rst_state",    int'(state),        0);
    chk("rst_cd_leds",  int'(cd_leds),      0);
    chk("rst_go_led",   int'(go_led),       0);
    chk("rst_react_ms", int'(react_ms),     0);
    chk("rst_rv",       int'(result_valid), 0);
    chk("rst_presc",    int'(presc_clr),    0);

    // Countdown pattern and hold-off length
    pulse_start();
    chk("start_state", int'(state),     1);
    chk("start_presc", int'(presc_clr), 1);
    chk("start_leds",  int'(cd_leds),   1);
    d2 = 0; d4 = 0; g = 0;
    while (int'(state) == 1 && g < 200) begin
      step(); g++;
      if (cd_leds == 8'h02) d2++;
      if (cd_leds == 8'h04) d4++;
    end
    chk("leds02_cycles", d2, 8);
    chk("leds04_cycles", d4, 8);
    chk("holdoff_state", int'(state),   2);
    chk("holdoff_leds",  int'(cd_leds), 0);
    t0 = tick_count;
    wait_state(3, 6000, "reach_go");
    chk("hold_ticks",   tick_count - t0, hold_load);
    chk("go_presc_clr", int'(presc_clr), 1);
    chk("go_led_on",    int'(go_led),    1);

    // Valid reaction after 7 ticks
    t0 = tick_count; g = 0;
    while (tick_count != t0 + 7 && g < 200) begin step(); g++; end
    press_once();
    chk("react7_state", int'(state),        4);
    chk("react7_ms",    int'(react_ms),     7);
    chk("react7_rv",    int'(result_valid), 1);
    chk("react7_goled", int'(go_led),       0);
    step();
    chk("react7_rv_single", int'(result_valid), 0);

    // Early press during second countdown step
    pulse_start();
    wait_leds(2, 50);
    press_once();
    chk("dq_cd_state", int'(state),        5);
    chk("dq_cd_leds",  int'(cd_leds),      0);
    chk("dq_cd_rv",    int'(result_valid), 0);
    chk("dq_cd_react", int'(react_ms),     7);

    // Early press inside hold-off
    pulse_start();
    wait_state(2, 100, "dq_hold_reach");
    step();
    press_once();
    chk("dq_hold_state", int'(state),        5);
    chk("dq_hold_rv",    int'(result_valid), 0);

    // Press on the exact HOLDOFF->GO tick
    pulse_start();
    wait_state(2, 100, "dq_edge_reach");
    g = 0;
    while (!(hold_left == 1 && tick_next()) && g < 6000) begin step(); g++; end
    press_once();
    chk("dq_edge_state", int'(state),    5);
    chk("dq_edge_goled", int'(go_led),   0);
    chk("dq_edge_react", int'(react_ms), 7);

    // Timeout with no press
    pulse_start();
    wait_state(3, 6000, "to_reach_go");
    wait_state(6, 200, "to_state");
    chk("to_react", int'(react_ms),     20);
    chk("to_rv",    int'(result_valid), 1);
    step();
    chk("to_rv_single", int'(result_valid), 0);

    // Press on the timeout tick wins
    pulse_start();
    wait_state(3, 6000, "tie_reach_go");
    t0 = tick_count; g = 0;
    while (!(tick_count == t0 + 19 && tick_next()) && g < 200) begin step(); g++; end
    press_once();
    chk("tie_state", int'(state),    4);
    chk("tie_react", int'(react_ms), 19);

    // Held button across a round, restart from RESULT, start ignored in GO
    button = 1'b1;
    step(2);
    pulse_start();
    chk("restart_state", int'(state),   1);
    chk("restart_leds",  int'(cd_leds), 1);
    wait_state(3, 6000, "held_reach_go");
    pulse_start();
    chk("start_in_go", int'(state),     3);
    chk("start_in_go_presc", int'(presc_clr), 0);
    wait_state(6, 200, "held_timeout");
    chk("held_react", int'(react_ms), 20);
    button = 1'b0;
    step(2);

    // Reset in the middle of GO
    pulse_start();
    wait_state(3, 6000, "rst_reach_go");
    step(5);
    reset = 1'b1; step(); reset = 1'b0;
    chk("midrst_state", int'(state),        0);
    chk("midrst_goled", int'(go_led),       0);
    chk("midrst_react", int'(react_ms),     0);
    chk("midrst_rv",    int'(result_valid), 0);
    step();
    chk("midrst_rv2",   int'(result_valid), 0);

    // Randomized rounds checked by the model every cycle
    for (int r = 0; r < 6; r++) begin
      mode = int'($urandom_range(0, 3));
      step(int'($urandom_range(1, 5)));
      pulse_start();
      case (mode)
        0: begin step(int'($urandom_range(0, 30))); press_once(); end
        1: begin
          wait_state(2, 100, "rnd_reach_hold");
          step(int'($urandom_range(0, 400)));
          if ($urandom_range(0, 3) == 0) pulse_start();
          if ($urandom_range(0, 4) == 0) begin reset = 1'b1; step(); reset = 1'b0; end
          press_once();
        end
        2: begin
          wait_state(3, 6000, "rnd_reach_go");
          step(int'($urandom_range(0, 100)));
          press_once();
        end
        default: begin
          wait_state(3, 6000, "rnd_reach_go");
          step(2);
          pulse_start();
        end
      endcase
      step(100);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reaction_game_ctrl.md
Name: reaction_game_ctrl

Overview:
Game sequencer for the reaction-time datapath. It consumes the 1 ms tick from the cascaded prescaler counters and runs a fixed LED countdown, then a pseudo-random hold-off, then a timed GO window. It clears and aligns the upstream prescaler, measures the button response in ms, and flags early presses (disqualify) and no-press timeouts. The top level turns its outputs into LEDG drive and HEX digits ("dis" on disqualify).

Parameters:
COUNTDOWN_STEPS, 4, number of LED countdown steps (1..8)
STEP_MS, 500, duration of each countdown step in ms (>=1)
MIN_HOLD_MS, 250, fixed part of the random hold-off in ms (>=1)
TIMEOUT_MS, 999, maximum measurable reaction; reaching it ends the round (<=1023)

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-high; clears all state
msec_tick  input  1  one-cycle pulse per ms from the prescaler chain
start  input  1  one-cycle pulse; begins or restarts a round
button  input  1  player button, already synchronized, 1 = pressed
presc_clr  output  1  one-cycle clear to the upstream prescaler counters
state  output  3  IDLE=0 COUNTDOWN=1 HOLDOFF=2 GO=3 RESULT=4 DISQUAL=5 TIMEOUT=6
cd_leds  output  8  countdown LED pattern
go_led  output  1  high while in GO
react_ms  output  10  latched reaction time in ms, binary
result_valid  output  1  one-cycle pulse when react_ms is updated

Behaviour:
- Reset values: state=IDLE, cd_leds=0, go_led=0, react_ms=0, result_valid=0, presc_clr=0. The LFSR loads 16'hACE1 and button_q loads 0.
- Press detect: button_q registers button every cycle. press = button & ~button_q. A held button never produces a second press.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clk, including in IDLE. Never all-zero.
- IDLE: outputs idle. start -> COUNTDOWN.
- On start, from IDLE, RESULT, DISQUAL or TIMEOUT:
  - presc_clr=1 for that cycle.
  - ms_cnt=0, step_cnt=0, cd_leds=8'h01.
  - react_ms is held, not cleared.
- start in COUNTDOWN, HOLDOFF or GO is ignored.
- COUNTDOWN:
  - Each msec_tick increments ms_cnt.
  - On a tick with ms_cnt==STEP_MS-1: ms_cnt=0.
    - If step_cnt==COUNTDOWN_STEPS-1: cd_leds=0, load hold=MIN_HOLD_MS+LFSR[9:0] (11 bits), go to HOLDOFF.
    - Otherwise: step_cnt+1, cd_leds<<=1.
- HOLDOFF:
  - On a tick with hold==1: go to GO, react_cnt=0, presc_clr=1 for that cycle.
  - On any other tick: hold-1.
- Press in COUNTDOWN or HOLDOFF, including the cycle that transitions into GO, goes to DISQUAL. Press has priority over every tick event that cycle. cd_leds=0.
- GO:
  - go_led=1.
  - Each tick: react_cnt+1.
  - Press: react_ms=react_cnt (value before any same-cycle increment), result_valid=1 the next cycle, go to RESULT.
  - Tick with react_cnt==TIMEOUT_MS-1 and no press: react_ms=TIMEOUT_MS, result_valid pulse, go to TIMEOUT.
  - Press wins over timeout in the same cycle.
- RESULT, DISQUAL, TIMEOUT: hold outputs. go_led=0. Exit only via start or reset.
- react_cnt never exceeds TIMEOUT_MS. No wrap.
- Reset mid-round: the next cycle is IDLE with all outputs at reset values. No result_valid is emitted.
- Latency: state, cd_leds and go_led change one cycle after the triggering input (registered outputs).

Test Plan:
Test parameters are STEP_MS=2, COUNTDOWN_STEPS=3, MIN_HOLD_MS=1, TIMEOUT_MS=20, and msec_tick every 4 clk.
1. Countdown and hold-off: reset, start, no press -> presc_clr one cycle; cd_leds 01, 02, 04, each lasting 2 ticks; cd_leds=0 and state=HOLDOFF. The number of ticks until state=GO equals 1+LFSR[9:0] sampled at the HOLDOFF entry cycle (check against the bench LFSR model). presc_clr pulses on GO entry.
2. Valid reaction: press after 7 ticks in GO -> react_ms=7, result_valid single pulse, state=RESULT, go_led=0.
3. Early press: press during cd_leds=02 -> state=DISQUAL, cd_leds=0, no result_valid, react_ms unchanged. Repeat with the press in HOLDOFF and with the press on the exact HOLDOFF->GO cycle -> DISQUAL each time.
4. Timeout: no press in GO -> after 20 ticks react_ms=20, result_valid pulse, state=TIMEOUT. Press on that same tick -> RESULT with react_ms=19.
5. Held button and restart: button held high from before GO -> no press is detected and the round times out. start during GO is ignored; start in RESULT -> COUNTDOWN with cd_leds=01.
6. Reset mid-GO: assert reset for 1 cycle -> state=IDLE, go_led=0, react_ms=0, no result_valid.
